// File: rtl/mode_ctrl_pkg.sv
// Shared mode encoding and data widths for the settings controller.
// Anything that decodes the mode output should import this package.
package mode_ctrl_pkg;

  typedef enum logic [1:0] {
    STATE_GAME   = 2'd0,
    STATE_VOLUME = 2'd1,
    STATE_LEVEL  = 2'd2
  } mode_e;

  localparam int VOL_W   = 7;
  localparam int LVL_W   = 2;
  localparam int DIGIT_W = 4;

endpackage

// File: rtl/idle_timer.sv
// Counts enabled cycles.
// Pulses expire on the last cycle of the window, then restarts from zero.
module idle_timer #(
  parameter int IDLE_CYC = 300000000,
  parameter int IDLE_W   = 29
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [IDLE_W-1:0] LAST = IDLE_W'(IDLE_CYC - 1);

  logic [IDLE_W-1:0] cnt_reg;

  assign expire = en && (cnt_reg == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr || expire) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/mode_ctrl.sv
// Front-panel settings controller: mode FSM, saturating volume and level editing,
// idle auto-return to game mode, and a BCD split of the volume for the display.
module mode_ctrl
  import mode_ctrl_pkg::*;
#(
  parameter int VOL_MAX  = 15,
  parameter int VOL_INIT = 8,
  parameter int LVL_MAX  = 3,
  parameter int LVL_INIT = 1,
  parameter int IDLE_CYC = 300000000,
  parameter int IDLE_W   = 29
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_mode,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               lock,
  output logic [1:0]         mode,
  output logic [LVL_W-1:0]   level,
  output logic [VOL_W-1:0]   vol,
  output logic [DIGIT_W-1:0] vol_ten,
  output logic [DIGIT_W-1:0] vol_uni,
  output logic               chg
);

  localparam logic [VOL_W-1:0] VOL_MAX_L  = VOL_W'(VOL_MAX);
  localparam logic [VOL_W-1:0] VOL_INIT_L = VOL_W'(VOL_INIT);
  localparam logic [LVL_W-1:0] LVL_MAX_L  = LVL_W'(LVL_MAX);
  localparam logic [LVL_W-1:0] LVL_INIT_L = LVL_W'(LVL_INIT);

  mode_e            mode_reg;
  logic [LVL_W-1:0] level_reg;
  logic [VOL_W-1:0] vol_reg;
  logic             chg_reg;
  logic             expire;
  logic             any_btn;

  assign any_btn = btn_mode || btn_up || btn_down;

  // The counter only runs outside game mode; every press restarts the window.
  idle_timer #(
    .IDLE_CYC(IDLE_CYC),
    .IDLE_W  (IDLE_W)
  ) u_idle_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (any_btn || (mode_reg == STATE_GAME)),
    .en    (mode_reg != STATE_GAME),
    .expire(expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_reg  <= STATE_GAME;
      level_reg <= LVL_INIT_L;
      vol_reg   <= VOL_INIT_L;
      chg_reg   <= 1'b0;
    end else begin
      chg_reg <= 1'b0;
      if ((mode_reg != STATE_GAME) && (lock || expire)) begin
        // A running game or a timeout abandons any edit pending this cycle.
        mode_reg <= STATE_GAME;
      end else if (btn_mode) begin
        case (mode_reg)
          STATE_GAME:   if (!lock) mode_reg <= STATE_VOLUME;
          STATE_VOLUME: mode_reg <= STATE_LEVEL;
          default:      mode_reg <= STATE_GAME;
        endcase
      end else if (btn_up != btn_down) begin
        case (mode_reg)
          STATE_VOLUME: begin
            if (btn_up && (vol_reg < VOL_MAX_L)) begin
              vol_reg <= vol_reg + 1'b1;
              chg_reg <= 1'b1;
            end else if (btn_down && (vol_reg != '0)) begin
              vol_reg <= vol_reg - 1'b1;
              chg_reg <= 1'b1;
            end
          end
          STATE_LEVEL: begin
            if (btn_up && (level_reg < LVL_MAX_L)) begin
              level_reg <= level_reg + 1'b1;
              chg_reg   <= 1'b1;
            end else if (btn_down && (level_reg > LVL_W'(1))) begin
              level_reg <= level_reg - 1'b1;
              chg_reg   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign mode    = mode_reg;
  assign level   = level_reg;
  assign vol     = vol_reg;
  assign chg     = chg_reg;
  assign vol_ten = DIGIT_W'(vol_reg / VOL_W'(10));
  assign vol_uni = DIGIT_W'(vol_reg % VOL_W'(10));

endmodule

// File: tb/tb_mode_ctrl.sv
// Directed bench for mode_ctrl: the driver queues the expected post-edge state
// for every cycle it drives, and a monitor checks each one after the edge.
module tb_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       lock = 1'b0;
  logic [1:0] mode;
  logic [1:0] level;
  logic [6:0] vol;
  logic [3:0] vol_ten;
  logic [3:0] vol_uni;
  logic       chg;

  typedef struct {
    string      name;
    logic [1:0] mode;
    logic [1:0] level;
    logic [6:0] vol;
    logic [3:0] ten;
    logic [3:0] uni;
    logic       chg;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   tx_id = 0;

  mode_ctrl #(
    .VOL_MAX (15),
    .VOL_INIT(8),
    .LVL_MAX (3),
    .LVL_INIT(1),
    .IDLE_CYC(16),
    .IDLE_W  (5)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_mode(btn_mode),
    .btn_up  (btn_up),
    .btn_down(btn_down),
    .lock    (lock),
    .mode    (mode),
    .level   (level),
    .vol     (vol),
    .vol_ten (vol_ten),
    .vol_uni (vol_uni),
    .chg     (chg)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the state expected after the next edge.
  task automatic step(input logic m, input logic u, input logic d, input logic lk,
                      input logic r, input int em, input int el, input int ev,
                      input logic ec, input string name);
    exp_t e;
    @(negedge clk);
    btn_mode = m;
    btn_up   = u;
    btn_down = d;
    lock     = lk;
    rst      = r;
    e.name  = name;
    e.mode  = 2'(em);
    e.level = 2'(el);
    e.vol   = 7'(ev);
    e.ten   = 4'(ev / 10);
    e.uni   = 4'(ev % 10);
    e.chg   = ec;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_cmp++;
        tx_id++;
        if (mode !== e.mode || level !== e.level || vol !== e.vol ||
            vol_ten !== e.ten || vol_uni !== e.uni || chg !== e.chg) begin
          n_bad++;
          $display("FAIL tx %0d %s: got mode=%0d level=%0d vol=%0d ten=%0d uni=%0d chg=%0d, want mode=%0d level=%0d vol=%0d ten=%0d uni=%0d chg=%0d",
                   tx_id, e.name, mode, level, vol, vol_ten, vol_uni, chg,
                   e.mode, e.level, e.vol, e.ten, e.uni, e.chg);
        end else begin
          $display("ok   tx %0d %s: mode=%0d level=%0d vol=%0d ten=%0d uni=%0d chg=%0d",
                   tx_id, e.name, mode, level, vol, vol_ten, vol_uni, chg);
        end
      end
    end
  end

  initial begin : driver
    // Reset state
    step(0, 0, 0, 0, 1, 0, 1, 8, 0, "reset");
    step(0, 0, 0, 0, 1, 0, 1, 8, 0, "reset");

    // Mode sequencing and lock in game mode
    step(1, 0, 0, 0, 0, 1, 1, 8, 0, "mode_game_to_vol");
    step(0, 0, 0, 0, 0, 1, 1, 8, 0, "mode_hold");
    step(1, 0, 0, 0, 0, 2, 1, 8, 0, "mode_vol_to_lvl");
    step(0, 0, 0, 0, 0, 2, 1, 8, 0, "mode_hold");
    step(1, 0, 0, 0, 0, 0, 1, 8, 0, "mode_lvl_to_game");
    step(0, 1, 0, 0, 0, 0, 1, 8, 0, "game_up_ignored");
    step(1, 0, 0, 1, 0, 0, 1, 8, 0, "lock_blocks_mode");

    // Volume up to saturation, then down to zero
    step(1, 0, 0, 0, 0, 1, 1, 8, 0, "enter_vol");
    for (int i = 1; i <= 8; i++)
      step(0, 1, 0, 0, 0, 1, 1, (8 + i > 15) ? 15 : 8 + i, (8 + i <= 15), "vol_up");
    for (int i = 1; i <= 16; i++)
      step(0, 0, 1, 0, 0, 1, 1, (15 - i < 0) ? 0 : 15 - i, (i <= 15), "vol_down");

    // Level editing
    step(1, 0, 0, 0, 0, 2, 1, 0, 0, "enter_lvl");
    step(0, 1, 0, 0, 0, 2, 2, 0, 1, "lvl_up");
    step(0, 1, 0, 0, 0, 2, 3, 0, 1, "lvl_up");
    step(0, 1, 0, 0, 0, 2, 3, 0, 0, "lvl_up_sat");
    step(0, 0, 1, 0, 0, 2, 2, 0, 1, "lvl_down");
    step(0, 0, 1, 0, 0, 2, 1, 0, 1, "lvl_down");
    step(0, 0, 1, 0, 0, 2, 1, 0, 0, "lvl_down_sat");
    step(0, 1, 1, 0, 0, 2, 1, 0, 0, "up_down_both");

    // Idle timeout: 16 edges after entering level mode
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, "to_game");
    step(1, 0, 0, 0, 0, 1, 1, 0, 0, "to_vol");
    step(1, 0, 0, 0, 0, 2, 1, 0, 0, "to_lvl_entry");
    for (int k = 1; k <= 15; k++)
      step(0, 0, 0, 0, 0, 2, 1, 0, 0, "idle_wait");
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, "idle_expire");

    // A press at edge 10 restarts the window
    step(1, 0, 0, 0, 0, 1, 1, 0, 0, "to_vol");
    step(1, 0, 0, 0, 0, 2, 1, 0, 0, "to_lvl_entry");
    for (int k = 1; k <= 9; k++)
      step(0, 0, 0, 0, 0, 2, 1, 0, 0, "idle_wait");
    step(0, 1, 0, 0, 0, 2, 2, 0, 1, "idle_restart_up");
    for (int k = 1; k <= 15; k++)
      step(0, 0, 0, 0, 0, 2, 2, 0, 0, "idle_wait2");
    step(0, 0, 0, 0, 0, 0, 2, 0, 0, "idle_expire2");

    // Mode press wins over up, lock forces game, reset mid-edit
    step(1, 0, 0, 0, 0, 1, 2, 0, 0, "enter_vol");
    for (int i = 1; i <= 12; i++)
      step(0, 1, 0, 0, 0, 1, 2, i, 1, "vol_up_to_12");
    step(1, 1, 0, 0, 0, 2, 2, 12, 0, "mode_beats_up");
    step(1, 0, 0, 0, 0, 0, 2, 12, 0, "to_game");
    step(1, 0, 0, 0, 0, 1, 2, 12, 0, "to_vol");
    step(0, 1, 0, 1, 0, 0, 2, 12, 0, "lock_forces_game");
    step(1, 0, 0, 0, 0, 1, 2, 12, 0, "to_vol");
    step(0, 1, 0, 0, 1, 0, 1, 8, 0, "rst_mid_edit");
    step(0, 0, 0, 0, 0, 0, 1, 8, 0, "after_rst");

    @(negedge clk);
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    lock     = 1'b0;
    rst      = 1'b0;
    for (int w = 0; w < 10 && sb.size() != 0; w++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
